// File: rtl/minmax_sequencer.sv
// Session-based signed min/max tracker with a saturating sample counter.
// A single strict less-than comparator is time-shared between the min
// update (CMP_MIN) and the max update (CMP_MAX).

module comparator_lt #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a,
  input  logic signed [N-1:0] b,
  output logic                out
);

  // Signed strict less-than: equal operands never report true
  assign out = (a < b);

endmodule

module minmax_sequencer #(
  parameter int N  = 32,
  parameter int CW = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [N-1:0] in_data,
  input  logic                in_last,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic signed [N-1:0] min_out,
  output logic signed [N-1:0] max_out,
  output logic [CW-1:0]       count_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_CMP_MIN = 3'd2,
    S_CMP_MAX = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic signed [N-1:0] r_sample;
  logic signed [N-1:0] r_min;
  logic signed [N-1:0] r_max;
  logic                r_last;
  logic [CW-1:0]       r_count;

  logic                w_accept;
  logic                w_first;
  logic signed [N-1:0] w_cmp_a;
  logic signed [N-1:0] w_cmp_b;
  logic                w_lt;

  assign w_accept = in_valid & in_ready;
  // count is zero only before the first accepted sample of a session
  assign w_first  = (r_count == '0);

  // Route comparator operands: sample<min in CMP_MIN, max<sample in CMP_MAX
  always_comb begin
    w_cmp_a = r_sample;
    w_cmp_b = r_min;
    if (r_state == S_CMP_MAX) begin
      w_cmp_a = r_max;
      w_cmp_b = r_sample;
    end
  end

  comparator_lt #(.N(N)) u_cmp (
    .a   (w_cmp_a),
    .b   (w_cmp_b),
    .out (w_lt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_accept) begin
          if (w_first) w_state_nxt = in_last ? S_DONE : S_WAIT;
          else         w_state_nxt = S_CMP_MIN;
        end
      end
      S_CMP_MIN: w_state_nxt = S_CMP_MAX;
      S_CMP_MAX: w_state_nxt = r_last ? S_DONE : S_WAIT;
      S_DONE:    if (result_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready     = (r_state == S_WAIT);
    busy         = (r_state != S_IDLE);
    result_valid = (r_state == S_DONE);
  end

  // Sample capture, min/max updates and saturating count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample <= '0;
      r_last   <= 1'b0;
      r_min    <= '0;
      r_max    <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_count <= '0;
        S_WAIT: begin
          if (w_accept) begin
            r_sample <= in_data;
            r_last   <= in_last;
            if (w_first) begin
              r_min   <= in_data;
              r_max   <= in_data;
              r_count <= CNT_ONE;
            end
          end
        end
        S_CMP_MIN: if (w_lt) r_min <= r_sample;
        S_CMP_MAX: begin
          if (w_lt) r_max <= r_sample;
          if (r_count != CNT_MAX) r_count <= r_count + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  assign min_out   = r_min;
  assign max_out   = r_max;
  assign count_out = r_count;

endmodule

// File: tb/tb_minmax_sequencer.sv
// Directed bench for minmax_sequencer: stimulus changes and checks on the
// falling edge, DUT state changes on the rising edge.

module tb_minmax_sequencer;

  localparam int N  = 32;
  localparam int CW = 8;

  logic                clk;
  logic                rst;
  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic                in_last;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic signed [N-1:0] min_out;
  logic signed [N-1:0] max_out;
  logic [CW-1:0]       count_out;

  int n_total = 0;
  int n_pass  = 0;

  minmax_sequencer #(.N(N), .CW(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .min_out      (min_out),
    .max_out      (max_out),
    .count_out    (count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_busy"},     32'(busy), 32'd0);
    chk({tag, "_rv"},       32'(result_valid), 32'd0);
    chk({tag, "_min"},      min_out, 32'd0);
    chk({tag, "_max"},      max_out, 32'd0);
    chk({tag, "_count"},    32'(count_out), 32'd0);
  endtask

  task automatic open_session();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy",  32'(busy), 32'd1);
    chk("start_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic close_session();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("close_busy", 32'(busy), 32'd0);
    chk("close_rv",   32'(result_valid), 32'd0);
  endtask

  // Waits (bounded) for in_ready, then presents one sample for one cycle.
  // Returns on the falling edge just after the accepting rising edge.
  task automatic send(input logic signed [N-1:0] d, input logic last);
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (in_ready !== 1'b1) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  // Called right after send(); result_valid must rise exactly lat cycles after accept.
  task automatic expect_result(input int lat);
    for (int k = 1; k < lat; k++) begin
      chk("rv_early", 32'(result_valid), 32'd0);
      @(negedge clk);
    end
    chk("rv_latency", 32'(result_valid), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    result_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy",  32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);

    // Session A: 5, -3, 7(last)
    open_session();
    send(32'sd5, 1'b0);
    chk("a_first_stays_wait", 32'(in_ready), 32'd1);
    send(-32'sd3, 1'b0);
    chk("a_cmp_ready_low", 32'(in_ready), 32'd0);
    send(32'sd7, 1'b1);
    expect_result(3);
    chk("a_min",   min_out, 32'hFFFF_FFFD);
    chk("a_max",   max_out, 32'd7);
    chk("a_count", 32'(count_out), 32'd3);

    // Hold result 10 cycles with start asserted: nothing may move
    start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_rv",  32'(result_valid), 32'd1);
      chk("hold_min", min_out, 32'hFFFF_FFFD);
    end
    chk("hold_max",   max_out, 32'd7);
    chk("hold_count", 32'(count_out), 32'd3);
    chk("hold_ready", 32'(in_ready), 32'd0);
    start = 1'b0;
    close_session();

    // Session B: single most-negative sample
    open_session();
    send(32'sh8000_0000, 1'b1);
    expect_result(1);
    chk("b_min",   min_out, 32'h8000_0000);
    chk("b_max",   max_out, 32'h8000_0000);
    chk("b_count", 32'(count_out), 32'd1);
    close_session();

    // Session C: signed extremes
    open_session();
    send(32'sh7FFF_FFFF, 1'b0);
    send(32'sh8000_0000, 1'b1);
    expect_result(3);
    chk("c_min",   min_out, 32'h8000_0000);
    chk("c_max",   max_out, 32'h7FFF_FFFF);
    chk("c_count", 32'(count_out), 32'd2);
    close_session();

    // Session D: 300 samples of 4, count saturates, 1-of-3 in_ready cadence
    open_session();
    for (int i = 0; i < 300; i++) begin
      chk("d_ready_hi", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 32'sd4;
      in_last  = (i == 299);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (i != 0) begin
        chk("d_ready_lo1", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("d_ready_lo2", 32'(in_ready), 32'd0);
        @(negedge clk);
      end
    end
    chk("d_rv",    32'(result_valid), 32'd1);
    chk("d_min",   min_out, 32'd4);
    chk("d_max",   max_out, 32'd4);
    chk("d_count", 32'(count_out), 32'd255);
    close_session();

    // Session E: reset asserted during CMP_MIN
    open_session();
    send(32'sd100, 1'b0);
    send(32'sd50, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    open_session();
    send(-32'sd10, 1'b0);
    send(32'sd20, 1'b1);
    expect_result(3);
    chk("e_min",   min_out, 32'hFFFF_FFF6);
    chk("e_max",   max_out, 32'd20);
    chk("e_count", 32'(count_out), 32'd2);
    close_session();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
